// File: rtl/issuer_pkg.sv
// Shared widths, instruction field positions and issue FSM states for the instruction issuer.
package issuer_pkg;

  localparam int WORD_W   = 12;
  localparam int NIB_W    = 4;
  localparam int OP0_HI   = 10;
  localparam int OP0_LO   = 8;
  localparam int OP1_HI   = 6;
  localparam int OP1_LO   = 4;
  localparam int IMM0_BIT = 3;
  localparam int IMM1_BIT = 2;
  localparam int ALU_HI   = 1;
  localparam int ALU_LO   = 0;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} issue_state_t;

endpackage

// File: rtl/issue_fifo.sv
// Circular-buffer FIFO with occupancy count; the head word is presented directly from storage.
module issue_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/instr_issuer.sv
// Assembles 12-bit instructions from nibbles, buffers them and issues them with a PE slot tag.
// Optional push-side operand lint is enabled with the ISSUE_LINT_EN macro.
module instr_issuer
  import issuer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int NUM_PE = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NIB_W-1:0]            nib_in,
  input  logic                        nib_valid,
  output logic                        nib_ready,
  input  logic                        go,
  input  logic                        stop,
  output logic [WORD_W-1:0]           instr_out,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [$clog2(NUM_PE)-1:0]   slot,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        busy,
  output logic                        fault
);

  localparam int SLOT_W = $clog2(NUM_PE);

  issue_state_t            state;
  logic [1:0]              nib_cnt;
  logic [WORD_W-1:NIB_W]   partial_q;
  logic [SLOT_W-1:0]       slot_q;
  logic [WORD_W-1:0]       push_word;
  logic                    nib_fire;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign nib_ready   = (state != DRAIN) && ((nib_cnt != 2'd2) || !fifo_full);
  assign nib_fire    = nib_valid && nib_ready;
  assign push        = nib_fire && (nib_cnt == 2'd2);
  assign push_word   = {partial_q, nib_in};
  assign instr_valid = (state != IDLE) && !fifo_empty;
  assign pop         = instr_valid && instr_ready;
  assign busy        = (state != IDLE);
  assign slot        = slot_q;

  issue_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (push_word),
    .rd_data (instr_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // The first two nibbles are held here; the third goes straight into the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nib_cnt   <= '0;
      partial_q <= '0;
    end else if (flush) begin
      nib_cnt   <= '0;
      partial_q <= '0;
    end else if (nib_fire) begin
      if (nib_cnt == 2'd2) begin
        nib_cnt <= '0;
      end else begin
        nib_cnt <= nib_cnt + 2'd1;
        if (nib_cnt == 2'd0) partial_q[11:8] <= nib_in;
        else                 partial_q[7:4]  <= nib_in;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      slot_q <= '0;
    else if (flush)  slot_q <= '0;
    else if (pop)    slot_q <= slot_q + SLOT_W'(1);
  end

  // stop outranks go; DRAIN only leaves once nothing is buffered or arriving.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (go && !stop)         state <= RUN;
        RUN:     if (stop)                state <= DRAIN;
        DRAIN:   if (fifo_empty && !push) state <= IDLE;
        default:                          state <= IDLE;
      endcase
    end
  end

`ifdef ISSUE_LINT_EN
  logic [SLOT_W-1:0] ps;
  logic              fault_q;
  logic              lint_hit;

  always_comb begin
    lint_hit = 1'b0;
    if (!push_word[IMM0_BIT] && (32'(push_word[OP0_HI:OP0_LO]) >= 32'(ps))) lint_hit = 1'b1;
    if (!push_word[IMM1_BIT] && (32'(push_word[OP1_HI:OP1_LO]) >= 32'(ps))) lint_hit = 1'b1;
  end

  // A register operand must name a PE slot already issued; offending words still go out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ps      <= '0;
      fault_q <= 1'b0;
    end else if (flush) begin
      ps      <= '0;
      fault_q <= 1'b0;
    end else if (push) begin
      ps <= ps + SLOT_W'(1);
      if (lint_hit) fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: directed vector table, multi-cycle sequences and
// randomized traffic compared against a queue-based reference model.
module tb_instr_issuer;

  localparam int DEPTH  = 4;
  localparam int NUM_PE = 4;
`ifdef ISSUE_LINT_EN
  localparam bit LINT_ON = 1'b1;
`else
  localparam bit LINT_ON = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  nib_in = '0;
  logic        nib_valid = 1'b0;
  logic        go = 1'b0;
  logic        stop = 1'b0;
  logic        instr_ready = 1'b0;
  logic        nib_ready;
  logic [11:0] instr_out;
  logic        instr_valid;
  logic [1:0]  slot;
  logic [2:0]  count;
  logic        busy;
  logic        fault;

  instr_issuer #(.DEPTH(DEPTH), .NUM_PE(NUM_PE)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .nib_in      (nib_in),
    .nib_valid   (nib_valid),
    .nib_ready   (nib_ready),
    .go          (go),
    .stop        (stop),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .slot        (slot),
    .count       (count),
    .busy        (busy),
    .fault       (fault)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: a plain queue of buffered words plus a few scalars.
  logic [11:0] mq[$];
  int          m_nibs;
  logic [11:0] m_part;
  bit          m_active;
  bit          m_drain;
  int          m_slot;
  int          m_ps;
  bit          m_fault;

  logic [11:0] got_w[$];
  int          got_s[$];

  function automatic void model_reset();
    mq.delete();
    m_nibs = 0; m_part = '0; m_active = 0; m_drain = 0;
    m_slot = 0; m_ps = 0; m_fault = 0;
  endfunction

  function automatic bit model_nib_ready();
    return !m_drain && !(m_nibs == 2 && mq.size() == DEPTH);
  endfunction

  function automatic bit model_valid();
    return m_active && (mq.size() != 0);
  endfunction

  function automatic void model_step();
    bit acc, pop, psh;
    logic [11:0] w;
    if (flush) begin
      model_reset();
      return;
    end
    acc = nib_valid && model_nib_ready();
    pop = model_valid() && instr_ready;
    psh = 0;
    w   = '0;
    if (acc) begin
      if (m_nibs == 0) begin m_part = {nib_in, 8'h00}; m_nibs = 1; end
      else if (m_nibs == 1) begin m_part = m_part | {4'h0, nib_in, 4'h0}; m_nibs = 2; end
      else begin w = m_part | {8'h00, nib_in}; psh = 1; m_nibs = 0; end
    end
    if (psh) begin
      if (LINT_ON && ((!w[3] && w[10:8] >= m_ps) || (!w[2] && w[6:4] >= m_ps))) m_fault = 1;
      m_ps = (m_ps + 1) % NUM_PE;
    end
    if (!m_active) begin
      if (go && !stop) m_active = 1;
    end else if (!m_drain) begin
      if (stop) m_drain = 1;
    end else if (mq.size() == 0 && !psh) begin
      m_active = 0;
      m_drain  = 0;
    end
    if (pop) begin
      void'(mq.pop_front());
      m_slot = (m_slot + 1) % NUM_PE;
    end
    if (psh) mq.push_back(w);
  endfunction

  task automatic check_output();
    check("model nib_ready", nib_ready, model_nib_ready());
    check("model instr_valid", instr_valid, model_valid());
    check("model count", count, mq.size());
    check("model slot", slot, m_slot);
    check("model busy", busy, m_active);
    check("model fault", fault, m_fault);
    if (model_valid()) check("model instr_out", instr_out, mq[0]);
  endtask

  task automatic apply_stimulus(input bit nv, input logic [3:0] n, input bit g, input bit s,
                                input bit ir, input bit fl);
    nib_valid   = nv;
    nib_in      = n;
    go          = g;
    stop        = s;
    instr_ready = ir;
    flush       = fl;
  endtask

  // One clock: note what the model expects to happen, advance both, compare at the falling edge.
  task automatic tick(output bit acc, output bit popped);
    acc    = nib_valid && model_nib_ready() && !flush;
    popped = model_valid() && instr_ready && !flush;
    if (popped) begin
      got_w.push_back(instr_out);
      got_s.push_back(int'(slot));
    end
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_output();
  endtask

  task automatic step_one();
    bit a, p;
    tick(a, p);
  endtask

  task automatic send_word(input logic [11:0] word, input bit ir);
    for (int i = 0; i < 3; i++) begin
      bit acc, pp;
      int tries = 0;
      do begin
        apply_stimulus(1'b1, word[11-4*i -: 4], 1'b0, 1'b0, ir, 1'b0);
        tick(acc, pp);
        tries++;
      end while (!acc && tries < 20);
      if (!acc) check("nibble accepted in time", 32'd0, 32'd1);
    end
    apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0, ir, 1'b0);
  endtask

  typedef struct {
    bit          nv;
    logic [3:0]  nib;
    bit          go;
    bit          stop;
    bit          ir;
    bit          fl;
    bit          e_valid;
    logic [11:0] e_out;
    int          e_slot;
    int          e_count;
    bit          e_busy;
    bit          e_nrdy;
  } vec_t;

  vec_t vecs[7];

  localparam logic [11:0] FILL_W [5] = '{12'h3A5, 12'h0F1, 12'h7E2, 12'hC48, 12'h9B6};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit acc, pp, done15;
    int tries;
    logic [11:0] w4;

    vecs[0] = '{0, 4'h0, 1, 0, 1, 0, 0, 12'h000, 0, 0, 1, 1};
    vecs[1] = '{1, 4'h1, 0, 0, 1, 0, 0, 12'h000, 0, 0, 1, 1};
    vecs[2] = '{1, 4'h2, 0, 0, 1, 0, 0, 12'h000, 0, 0, 1, 1};
    vecs[3] = '{1, 4'hC, 0, 0, 1, 0, 1, 12'h12C, 0, 1, 1, 1};
    vecs[4] = '{0, 4'h0, 0, 0, 1, 0, 0, 12'h000, 1, 0, 1, 1};
    vecs[5] = '{0, 4'h0, 0, 1, 1, 0, 0, 12'h000, 1, 0, 1, 0};
    vecs[6] = '{0, 4'h0, 0, 0, 1, 0, 0, 12'h000, 1, 0, 0, 1};

    model_reset();
    repeat (2) @(negedge clock);
    check("reset nib_ready", nib_ready, 1);
    check("reset instr_valid", instr_valid, 0);
    check("reset instr_out", instr_out, 0);
    check("reset slot", slot, 0);
    check("reset count", count, 0);
    check("reset busy", busy, 0);
    check("reset fault", fault, 0);
    reset = 1'b1;
    step_one();

    $display("[TB] basic issue vectors");
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].nv, vecs[i].nib, vecs[i].go, vecs[i].stop, vecs[i].ir, vecs[i].fl);
      tick(acc, pp);
      check($sformatf("vec%0d instr_valid", i), instr_valid, vecs[i].e_valid);
      if (vecs[i].e_valid) check($sformatf("vec%0d instr_out", i), instr_out, vecs[i].e_out);
      check($sformatf("vec%0d slot", i), slot, vecs[i].e_slot);
      check($sformatf("vec%0d count", i), count, vecs[i].e_count);
      check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d nib_ready", i), nib_ready, vecs[i].e_nrdy);
    end

    $display("[TB] fill, backpressure and hold");
    apply_stimulus(0, 4'h0, 0, 0, 0, 1); step_one();
    apply_stimulus(0, 4'h0, 1, 0, 0, 0); step_one();
    for (int i = 0; i < 4; i++) send_word(FILL_W[i], 1'b0);
    check("fill count", count, 4);
    w4 = FILL_W[4];
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, w4[11-4*i -: 4], 0, 0, 0, 0);
      tick(acc, pp);
      check("fill nibble not blocked", acc, 1);
    end
    check("nib_ready at 15th nibble", nib_ready, 0);
    apply_stimulus(1, w4[3:0], 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(acc, pp);
      check("15th nibble held off", acc, 0);
      check("hold instr_valid", instr_valid, 1);
      check("hold instr_out", instr_out, FILL_W[0]);
      check("hold slot", slot, 0);
    end
    got_w.delete(); got_s.delete();
    done15 = 0; tries = 0;
    while (got_w.size() < 5 && tries < 30) begin
      apply_stimulus(!done15, w4[3:0], 0, 0, 1, 0);
      tick(acc, pp);
      if (acc) done15 = 1;
      tries++;
    end
    check("drain word count", got_w.size(), 5);
    for (int i = 0; i < 5 && i < got_w.size(); i++) begin
      check($sformatf("order word%0d", i), got_w[i], FILL_W[i]);
      check($sformatf("order slot%0d", i), got_s[i], i % NUM_PE);
    end

    $display("[TB] stop and drain");
    send_word(12'h481, 1'b0);
    send_word(12'hE0F, 1'b0);
    got_w.delete(); got_s.delete();
    apply_stimulus(0, 4'h0, 0, 1, 0, 0); step_one();
    check("drain busy", busy, 1);
    check("drain nib_ready", nib_ready, 0);
    tries = 0;
    while (got_w.size() < 2 && tries < 10) begin
      apply_stimulus(0, 4'h0, 0, 0, 1, 0);
      step_one();
      check("drain refuses nibbles", nib_ready, 0);
      tries++;
    end
    check("drain issued", got_w.size(), 2);
    if (got_w.size() == 2) begin
      check("drain word0", got_w[0], 12'h481);
      check("drain word1", got_w[1], 12'hE0F);
    end
    check("busy right after last pop", busy, 1);
    step_one();
    check("busy falls", busy, 0);
    check("idle nib_ready", nib_ready, 1);

    $display("[TB] flush mid-word");
    apply_stimulus(0, 4'h0, 1, 0, 0, 0); step_one();
    apply_stimulus(1, 4'hA, 0, 0, 0, 0); step_one();
    apply_stimulus(1, 4'hB, 0, 0, 0, 0); step_one();
    apply_stimulus(0, 4'h0, 0, 0, 0, 1); step_one();
    check("flush count", count, 0);
    check("flush slot", slot, 0);
    check("flush busy", busy, 0);
    apply_stimulus(0, 4'h0, 1, 0, 0, 0); step_one();
    send_word(12'h5D3, 1'b0);
    check("post-flush valid", instr_valid, 1);
    check("post-flush word", instr_out, 12'h5D3);
    check("post-flush count", count, 1);
    apply_stimulus(0, 4'h0, 0, 0, 1, 0); step_one();
    check("post-flush pop", count, 0);

    $display("[TB] asynchronous reset mid-run");
    send_word(12'h7A1, 1'b0);
    apply_stimulus(1, 4'h9, 0, 0, 0, 0); step_one();
    apply_stimulus(0, 4'h0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("async reset nib_ready", nib_ready, 1);
    check("async reset instr_valid", instr_valid, 0);
    check("async reset instr_out", instr_out, 0);
    check("async reset slot", slot, 0);
    check("async reset count", count, 0);
    check("async reset busy", busy, 0);
    check("async reset fault", fault, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    apply_stimulus(0, 4'h0, 1, 0, 0, 0); step_one();
    send_word(12'h246, 1'b0);
    check("post-reset word", instr_out, 12'h246);
    check("post-reset count", count, 1);
    apply_stimulus(0, 4'h0, 0, 0, 1, 0); step_one();

    $display("[TB] operand lint");
    apply_stimulus(0, 4'h0, 0, 0, 0, 1); step_one();
    apply_stimulus(0, 4'h0, 1, 0, 0, 0); step_one();
    send_word(12'h100, 1'b0);
    check("lint fault on 100", fault, LINT_ON);
    check("lint word still issued", instr_out, 12'h100);
    check("lint word valid", instr_valid, 1);
    apply_stimulus(0, 4'h0, 0, 0, 1, 0); step_one();
    check("lint fault sticky", fault, LINT_ON);
    apply_stimulus(0, 4'h0, 0, 0, 0, 1); step_one();
    check("lint fault cleared by flush", fault, 0);
    apply_stimulus(0, 4'h0, 1, 0, 0, 0); step_one();
    send_word(12'h00C, 1'b0);
    check("lint no fault on 00C", fault, 0);
    apply_stimulus(0, 4'h0, 0, 0, 1, 0); step_one();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 23) == 0),
                     ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
      step_one();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
